// File: rtl/seg_scan_if.sv
// Load/display bundle for the multiplexed 7-segment scanner: the host side
// drives load/value, the display side returns status and the scan outputs.
interface seg_scan_if;
  logic        load;
  logic [13:0] value;
  logic        busy;
  logic        ovf;
  logic [7:0]  seg_out;
  logic [3:0]  dig_en;

  modport master (
    output load, value,
    input  busy, ovf, seg_out, dig_en
  );

  modport slave (
    input  load, value,
    output busy, ovf, seg_out, dig_en
  );
endinterface

// File: rtl/seg_scan_display.sv
// Four-digit multiplexed 7-segment driver: a binary load is converted to BCD
// by a 14-step double-dabble, then scanned one digit per SCAN_DIV cycles.
module seg_scan_display #(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  typedef enum logic {IDLE, CONV} state_t;

  localparam int             CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [13:0]    VALUE_MAX = 14'd9999;
  localparam logic [3:0]     LAST_STEP = 4'd13;
  localparam logic [7:0]     SEG_DASH  = 8'h40;

  state_t        state, state_next;
  logic          start, finish, overflow_load;
  logic [3:0]    step;
  logic [13:0]   bin;
  logic [15:0]   bcd, bcd_adj, bcd_shift;
  logic [13:0]   bin_shift;
  logic [3:0]    digit [4];
  logic          ovf;

  logic [CW-1:0] scan_cnt;
  logic          scan_wrap;
  logic [1:0]    idx, idx_next;
  logic [3:0]    blank;
  logic [7:0]    seg_sel;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 8'h3F;
      4'd1:    seg_decode = 8'h06;
      4'd2:    seg_decode = 8'h5B;
      4'd3:    seg_decode = 8'h4F;
      4'd4:    seg_decode = 8'h66;
      4'd5:    seg_decode = 8'h6D;
      4'd6:    seg_decode = 8'h7D;
      4'd7:    seg_decode = 8'h07;
      4'd8:    seg_decode = 8'h7F;
      4'd9:    seg_decode = 8'h6F;
      default: seg_decode = 8'h00;
    endcase
  endfunction

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value held (which would infer a latch).
    state_next    = state;
    start         = 1'b0;
    finish        = 1'b0;
    overflow_load = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load) begin
          if (bus.value <= VALUE_MAX) begin
            start      = 1'b1;
            state_next = CONV;
          end else begin
            overflow_load = 1'b1;
          end
        end
      end
      CONV: begin
        // Loads are not looked at here, including on the completing edge.
        if (step == LAST_STEP) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state == CONV);
  assign bus.ovf  = ovf;

  // ------------------------------------------------------------ conversion
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 4; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3
                                                  : bcd[4*i +: 4];
    end
  end

  assign bcd_shift = {bcd_adj[14:0], bin[13]};
  assign bin_shift = {bin[12:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the digit registers are reset because the reset display value
    // ("0" on digit 0) is defined by them, not just by the output flops.
    if (rst) begin
      step  <= '0;
      bin   <= '0;
      bcd   <= '0;
      ovf   <= 1'b0;
      for (int i = 0; i < 4; i++) digit[i] <= '0;
    end else begin
      if (start) begin
        bin  <= bus.value;
        bcd  <= '0;
        step <= '0;
      end else if (state == CONV) begin
        bin  <= bin_shift;
        bcd  <= bcd_shift;
        step <= step + 4'd1;
      end
      if (finish) begin
        for (int i = 0; i < 4; i++) digit[i] <= bcd_shift[4*i +: 4];
        ovf <= 1'b0;
      end
      if (overflow_load) ovf <= 1'b1;
    end
  end

  // ------------------------------------------------------------------ scan
  assign scan_wrap = (scan_cnt == CNT_MAX);
  assign idx_next  = scan_wrap ? idx + 2'd1 : idx;

  // A digit is blank only if it and every more significant digit is zero.
  assign blank[3] = BLANK_LZ && (digit[3] == 4'd0);
  assign blank[2] = blank[3] && (digit[2] == 4'd0);
  assign blank[1] = blank[2] && (digit[1] == 4'd0);
  assign blank[0] = 1'b0;

  always_comb begin
    if (ovf)                  seg_sel = SEG_DASH;
    else if (blank[idx_next]) seg_sel = 8'h00;
    else                      seg_sel = seg_decode(digit[idx_next]);
  end

  // Segments and enable are registered from the same next index so the
  // pair always switches together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt    <= '0;
      idx         <= '0;
      bus.dig_en  <= 4'b0001;
      bus.seg_out <= 8'h3F;
    end else begin
      scan_cnt    <= scan_wrap ? '0 : scan_cnt + CW'(1);
      idx         <= idx_next;
      bus.dig_en  <= 4'b0001 << idx_next;
      bus.seg_out <= seg_sel;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with a short scan period so full digit
// rotations fit in a few dozen cycles.
module tb_seg_scan_display;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  logic [7:0] seen [4];

  seg_scan_if bus ();

  seg_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input int v);
    @(negedge clk);
    bus.load  = 1'b1;
    bus.value = 14'(v);
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic scan_capture();
    for (int i = 0; i < 4; i++) seen[i] = 8'hxx;
    @(negedge clk);
    repeat (20) begin
      @(negedge clk);
      case (bus.dig_en)
        4'b0001: seen[0] = bus.seg_out;
        4'b0010: seen[1] = bus.seg_out;
        4'b0100: seen[2] = bus.seg_out;
        4'b1000: seen[3] = bus.seg_out;
        default: seen[0] = 8'hEE;
      endcase
    end
  endtask

  task automatic check_scan(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    scan_capture();
    check({tag, "_d0"}, seen[0], e0);
    check({tag, "_d1"}, seen[1], e1);
    check({tag, "_d2"}, seen[2], e2);
    check({tag, "_d3"}, seen[3], e3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] exp_en;

    // Reset: values must be present before any clock edge.
    rst       = 1'b1;
    bus.load  = 1'b0;
    bus.value = '0;
    #1;
    check("rst_dig_en", bus.dig_en, 4'b0001);
    check("rst_seg", bus.seg_out, 8'h3F);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ovf", bus.ovf, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_dig_en", bus.dig_en, 4'b0001);
    check("rel_seg", bus.seg_out, 8'h3F);
    check("rel_busy", bus.busy, 1'b0);
    check("rel_ovf", bus.ovf, 1'b0);

    // Scan rotation: first slot lasts 4 cycles, then 0010, 0100, 1000, wrap.
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_en = 4'b0001 << ((k / 4) % 4);
      check("scan_dig_en", bus.dig_en, exp_en);
    end

    do_load(1234);
    wait_busy(n);
    check("busy_1234", n, 14);
    check("ovf_1234", bus.ovf, 1'b0);
    check_scan("v1234", 8'h66, 8'h4F, 8'h5B, 8'h06);

    do_load(7);
    wait_busy(n);
    check("busy_7", n, 14);
    check_scan("v7", 8'h07, 8'h00, 8'h00, 8'h00);

    do_load(0);
    wait_busy(n);
    check("busy_0", n, 14);
    check_scan("v0", 8'h3F, 8'h00, 8'h00, 8'h00);

    do_load(305);
    wait_busy(n);
    check("busy_305", n, 14);
    check_scan("v305", 8'h6D, 8'h3F, 8'h4F, 8'h00);

    // Overflow: no conversion, dashes on every digit.
    do_load(10000);
    check("ovf_set", bus.ovf, 1'b1);
    check("ovf_busy", bus.busy, 1'b0);
    check_scan("v_ovf", 8'h40, 8'h40, 8'h40, 8'h40);

    do_load(9999);
    check("ovf_hold_conv", bus.ovf, 1'b1);
    wait_busy(n);
    check("busy_9999", n, 14);
    check("ovf_clr", bus.ovf, 1'b0);
    check_scan("v9999", 8'h6F, 8'h6F, 8'h6F, 8'h6F);

    // Load on the completing edge is dropped.
    do_load(5678);
    repeat (13) @(negedge clk);
    bus.load  = 1'b1;
    bus.value = 14'd1111;
    @(negedge clk);
    bus.load  = 1'b0;
    check("last_edge_busy", bus.busy, 1'b0);
    @(negedge clk);
    check("last_edge_busy2", bus.busy, 1'b0);
    check_scan("v5678", 8'h7F, 8'h07, 8'h7D, 8'h6D);

    // Load 42 then 99 three cycles later: 99 ignored.
    do_load(42);
    @(negedge clk);
    @(negedge clk);
    bus.load  = 1'b1;
    bus.value = 14'd99;
    @(negedge clk);
    bus.load  = 1'b0;
    wait_busy(n);
    check("busy_42", n, 11);
    check_scan("v42", 8'h5B, 8'h66, 8'h00, 8'h00);

    // Reset in the middle of a conversion discards it.
    do_load(42);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_ovf", bus.ovf, 1'b0);
    check("mid_rst_dig_en", bus.dig_en, 4'b0001);
    check("mid_rst_seg", bus.seg_out, 8'h3F);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_busy", bus.busy, 1'b0);
    check_scan("post_rst", 8'h3F, 8'h00, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
